// File: rtl/exu_share_arb.sv
// Round-robin time-sharing of one combinational EXU between two requesters, each with a 1-entry response buffer.
// Optional macro EXU_ARB_PERF_EN adds grant and conflict performance counters.
module exu_share_arb #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_mode,
  input  logic [DATAWIDTH-1:0] req0_src1,
  input  logic [DATAWIDTH-1:0] req0_src2,
  input  logic [DATAWIDTH-1:0] req0_imm,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_mode,
  input  logic [DATAWIDTH-1:0] req1_src1,
  input  logic [DATAWIDTH-1:0] req1_src2,
  input  logic [DATAWIDTH-1:0] req1_imm,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [DATAWIDTH-1:0] rsp0_data,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [DATAWIDTH-1:0] rsp1_data,
  output logic [3:0]           exu_mode,
  output logic [DATAWIDTH-1:0] exu_src1,
  output logic [DATAWIDTH-1:0] exu_src2,
  output logic [DATAWIDTH-1:0] exu_imm,
  input  logic [DATAWIDTH-1:0] exu_data
`ifdef EXU_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant0,
  output logic [31:0]          perf_grant1,
  output logic [31:0]          perf_conflict
`endif
);

  logic elig0_p0;
  logic elig1_p0;
  logic grant0_p0;
  logic grant1_p0;
  logic last_p1;

  // Stage p0: eligibility, round-robin grant and EXU operand mux (combinational)
  always_comb begin
    elig0_p0  = req0_valid && (!rsp0_valid || rsp0_ready);
    elig1_p0  = req1_valid && (!rsp1_valid || rsp1_ready);
    grant0_p0 = rst_n && elig0_p0 && (!elig1_p0 || last_p1);
    grant1_p0 = rst_n && elig1_p0 && (!elig0_p0 || !last_p1);
  end

  assign req0_ready = grant0_p0;
  assign req1_ready = grant1_p0;

  always_comb begin
    exu_mode = 4'b0000;
    exu_src1 = '0;
    exu_src2 = '0;
    exu_imm  = '0;
    if (grant0_p0) begin
      exu_mode = req0_mode;
      exu_src1 = req0_src1;
      exu_src2 = req0_src2;
      exu_imm  = req0_imm;
    end else if (grant1_p0) begin
      exu_mode = req1_mode;
      exu_src1 = req1_src1;
      exu_src2 = req1_src2;
      exu_imm  = req1_imm;
    end
  end

  // Stage p1: response buffers capture the EXU result; last tracks the previous winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      last_p1    <= 1'b1;
    end else begin
      if (grant0_p0) begin
        rsp0_data  <= exu_data;
        rsp0_valid <= 1'b1;
        last_p1    <= 1'b0;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (grant1_p0) begin
        rsp1_data  <= exu_data;
        rsp1_valid <= 1'b1;
        last_p1    <= 1'b1;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

`ifdef EXU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grant0   <= 32'd0;
      perf_grant1   <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (grant0_p0)            perf_grant0   <= perf_grant0 + 32'd1;
      if (grant1_p0)            perf_grant1   <= perf_grant1 + 32'd1;
      if (elig0_p0 && elig1_p0) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exu_share_arb.sv
// Directed bench for exu_share_arb with a behavioural EXU and per-port expected-result queues.
// Build with EXU_ARB_PERF_EN defined to also check the performance counters.
module tb_exu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_mode;
  logic [31:0] req0_src1, req0_src2, req0_imm;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_mode;
  logic [31:0] req1_src1, req1_src2, req1_imm;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
  logic [3:0]  exu_mode;
  logic [31:0] exu_src1, exu_src2, exu_imm, exu_data;
`ifdef EXU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  exu_share_arb #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_imm(req1_imm),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .exu_mode(exu_mode), .exu_src1(exu_src1), .exu_src2(exu_src2),
    .exu_imm(exu_imm), .exu_data(exu_data)
`ifdef EXU_ARB_PERF_EN
    ,
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural shared EXU
  always_comb begin
    exu_data = 32'd0;
    case (exu_mode)
      4'b0000: exu_data = exu_src1 + exu_src2;
      4'b0001: exu_data = exu_src1 + exu_imm;
      4'b0100: exu_data = (exu_src1 == exu_src2) ? 32'd0 : (exu_src1 > exu_src2) ? 32'd2 : 32'd4;
      4'b1000: exu_data = (exu_src1 == exu_src2) ? 32'd0 :
                          ($signed(exu_src1) > $signed(exu_src2)) ? 32'd2 : 32'd4;
      default: exu_data = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge with inputs already driven; checks grants, scores responses, advances one cycle.
  task automatic tick(input logic g0, input logic g1, input logic [31:0] e0, input logic [31:0] e1);
    #1;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    if (g0) begin
      q0.push_back(e0);
      chk("exu_src1_port0", exu_src1, req0_src1);
    end else if (g1) begin
      q1.push_back(e1);
      chk("exu_src1_port1", exu_src1, req1_src1);
    end else begin
      chk("exu_idle", {28'd0, exu_mode} | exu_src1 | exu_src2 | exu_imm, 32'd0);
    end
    if (rsp0_valid && rsp0_ready) begin
      if (q0.size() == 0) chk("rsp0_unexpected", {31'd0, rsp0_valid}, 32'd0);
      else chk("rsp0_data", rsp0_data, q0.pop_front());
    end
    if (rsp1_valid && rsp1_ready) begin
      if (q1.size() == 0) chk("rsp1_unexpected", {31'd0, rsp1_valid}, 32'd0);
      else chk("rsp1_data", rsp1_data, q1.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_mode = 4'b0000; req0_src1 = 32'd5; req0_src2 = 32'd7; req0_imm = 32'd0;
    req1_valid = 1'b0; req1_mode = 4'b0000; req1_src1 = 32'd0; req1_src2 = 32'd0; req1_imm = 32'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("reset_rsp0_data", rsp0_data, 32'd0);
    chk("reset_rsp1_data", rsp1_data, 32'd0);
    chk("reset_exu_mode", {28'd0, exu_mode}, 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Port 0 alone: 5 + 7
    req0_valid = 1'b1; req0_mode = 4'b0000; req0_src1 = 32'd5; req0_src2 = 32'd7;
    tick(1'b1, 1'b0, 32'd12, 32'd0);
    req0_valid = 1'b0;
    chk("solo_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("solo_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    tick(1'b0, 1'b0, 32'd0, 32'd0);

    // Contention straight after reset: alternation 0,1,0,1
    do_reset();
    req0_valid = 1'b1; req0_mode = 4'b0001; req0_src1 = 32'h10; req0_src2 = 32'd0; req0_imm = 32'hFFFF_FFFF;
    req1_valid = 1'b1; req1_mode = 4'b0100; req1_src1 = 32'd3; req1_src2 = 32'd9; req1_imm = 32'd0;
    tick(1'b1, 1'b0, 32'h0F, 32'd0);
    tick(1'b0, 1'b1, 32'd0, 32'd4);
    tick(1'b1, 1'b0, 32'h0F, 32'd0);
    tick(1'b0, 1'b1, 32'd0, 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(1'b0, 1'b0, 32'd0, 32'd0);

    // Signed compare on port 1
    req1_valid = 1'b1; req1_mode = 4'b1000; req1_src1 = 32'hFFFF_FFFE; req1_src2 = 32'd1;
    tick(1'b0, 1'b1, 32'd0, 32'd4);
    req1_src1 = 32'd1; req1_src2 = 32'hFFFF_FFFE;
    tick(1'b0, 1'b1, 32'd0, 32'd2);
    req1_src1 = 32'd77; req1_src2 = 32'd77;
    tick(1'b0, 1'b1, 32'd0, 32'd0);
    req1_valid = 1'b0;
    tick(1'b0, 1'b0, 32'd0, 32'd0);

    // Backpressure on port 0 while port 1 keeps flowing
    req0_valid = 1'b1; req0_mode = 4'b0000; req0_src1 = 32'h20; req0_src2 = 32'd0;
    tick(1'b1, 1'b0, 32'h20, 32'd0);
    rsp0_ready = 1'b0;
    req0_src1 = 32'h30;
    req1_valid = 1'b1; req1_mode = 4'b0000; req1_src1 = 32'd1; req1_src2 = 32'd1;
    tick(1'b0, 1'b1, 32'd0, 32'd2);
    chk("bp_rsp0_data", rsp0_data, 32'h20);
    req1_src1 = 32'd2; req1_src2 = 32'd2;
    tick(1'b0, 1'b1, 32'd0, 32'd4);
    chk("bp_rsp0_hold", rsp0_data, 32'h20);
    req1_src1 = 32'd3; req1_src2 = 32'd3;
    tick(1'b0, 1'b1, 32'd0, 32'd6);
    chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    rsp0_ready = 1'b1; req1_valid = 1'b0;
    tick(1'b1, 1'b0, 32'h30, 32'd0);
    chk("drain_accept_valid", {31'd0, rsp0_valid}, 32'd1);
    req0_valid = 1'b0;
    tick(1'b0, 1'b0, 32'd0, 32'd0);
    chk("drained_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);

    // Blocked requester does not take a turn, then reset discards buffered results
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_mode = 4'b0000; req0_src1 = 32'd1; req0_src2 = 32'd2;
    req1_valid = 1'b1; req1_mode = 4'b0000; req1_src1 = 32'd4; req1_src2 = 32'd4;
    tick(1'b0, 1'b1, 32'd0, 32'd8);
    tick(1'b1, 1'b0, 32'd3, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("full_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("full_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("full_rsp0_data", rsp0_data, 32'd3);
    chk("full_rsp1_data", rsp1_data, 32'd8);
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    do_reset();
    chk("mid_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("mid_rst_rsp0_data", rsp0_data, 32'd0);
    chk("mid_rst_rsp1_data", rsp1_data, 32'd0);
    req1_valid = 1'b1; rsp1_ready = 1'b1;
    tick(1'b1, 1'b0, 32'd3, 32'd0);
    tick(1'b0, 1'b1, 32'd0, 32'd8);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(1'b0, 1'b0, 32'd0, 32'd0);

    // Three conflict cycles then two solo port-1 accepts
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(1'b1, 1'b0, 32'd3, 32'd0);
    tick(1'b0, 1'b1, 32'd0, 32'd8);
    tick(1'b1, 1'b0, 32'd3, 32'd0);
    req0_valid = 1'b0;
    tick(1'b0, 1'b1, 32'd0, 32'd8);
    tick(1'b0, 1'b1, 32'd0, 32'd8);
    req1_valid = 1'b0;
    tick(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef EXU_ARB_PERF_EN
    chk("perf_grant0", perf_grant0, 32'd2);
    chk("perf_grant1", perf_grant1, 32'd3);
    chk("perf_conflict", perf_conflict, 32'd3);
`endif

    chk("q0_leftover", q0.size(), 32'd0);
    chk("q1_leftover", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_share_arb.md
Name: exu_share_arb

Overview:
- Time-shares one combinational EXU (add/sub/compare unit) between two requesters.
  - Port 0: the execute stage of the pipeline.
  - Port 1: the LSU address/compare path.
- Each requester has a valid/ready request channel and a 1-entry registered response buffer with its own valid/ready.
- Round-robin arbitration picks at most one operation per cycle.
- Sits between IDU/LSU and the EXU instance. Drives the EXU mode and operands, and captures the EXU result.

Parameters:
- DATAWIDTH, 32, width of operands and result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid).
- req0_mode  in  4  EXU mode code: 0000 add src1+src2, 0001 add src1+imm, 0100 unsigned compare, 1000 signed compare.
- req0_src1  in  DATAWIDTH  operand 1.
- req0_src2  in  DATAWIDTH  operand 2.
- req0_imm  in  DATAWIDTH  immediate.
- req1_valid, req1_ready, req1_mode, req1_src1, req1_src2, req1_imm: same as requester 0, for requester 1.
- rsp0_valid  out  1  response buffer 0 holds a result.
- rsp0_ready  in  1  consumer 0 takes the result.
- rsp0_data  out  DATAWIDTH  result for requester 0.
- rsp1_valid  out  1  response buffer 1 holds a result.
- rsp1_ready  in  1  consumer 1 takes the result.
- rsp1_data  out  DATAWIDTH  result for requester 1.
- exu_mode  out  4  mode to shared EXU.
- exu_src1  out  DATAWIDTH  operand 1 to EXU.
- exu_src2  out  DATAWIDTH  operand 2 to EXU.
- exu_imm  out  DATAWIDTH  immediate to EXU.
- exu_data  in  DATAWIDTH  combinational EXU result.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first conflict.
  - All optional counters = 0.
  - Reset asserted mid-operation discards any buffered results. A request presented during reset is not accepted: both ready = 0 while rst_n = 0.
- Eligibility: elig_i = req_i_valid && (!rsp_i_valid || rsp_i_ready). A requester whose full buffer is not draining cannot be granted.
- Grant:
  - Only one requester eligible: grant it.
  - Both eligible: grant 0 if last == 1, else grant 1.
  - Neither eligible: no grant.
  - Grant is combinational. req_i_ready = grant_i. At most one ready is high per cycle.
- EXU drive:
  - With a grant: exu_mode/src1/src2/imm = the granted requester's fields, combinationally.
  - Without a grant: all EXU outputs = 0 (mode 0000, result ignored).
- Accept edge (req_i_valid && req_i_ready):
  - rsp_i_data <= exu_data, rsp_i_valid <= 1, last <= i.
  - Latency: request accepted in cycle N, response valid in cycle N+1.
- Drain: rsp_i_ready && rsp_i_valid with no new accept for i gives rsp_i_valid <= 0. rsp_i_data holds its value.
- Simultaneous drain and accept on port i: rsp_i_valid stays 1 and rsp_i_data takes the new result. Sustains 1 op/cycle per port when no conflict.
- Stability:
  - rsp_i_data and rsp_i_valid do not change while rsp_i_valid && !rsp_i_ready.
  - Requesters hold their request fields stable while valid && !ready.
- Mode handling:
  - Mode codes are passed through unchecked.
  - An undefined code is still accepted and returns whatever the EXU produces (0 for undefined modes).
  - Compare results are passed through unchanged: 0 = equal, 2 = src1 > src2, 4 = src1 < src2.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- A blocked requester (buffer full, not draining) does not consume a turn: last is not updated, and the other requester is granted freely.

Optional Feature:
- Macro: EXU_ARB_PERF_EN.
- Defined: adds three outputs:
  - perf_grant0 (32 bits): increments on each port-0 accept.
  - perf_grant1 (32 bits): increments on each port-1 accept.
  - perf_conflict (32 bits): increments on each cycle with elig_0 && elig_1.
  - All three wrap modulo 2^32, clear on reset, and are registered, so the count is visible the cycle after the event.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Port 0 only, mode 0000, src1=5, src2=7; rsp0_ready=1 -> req0_ready=1 in cycle N; rsp0_valid=1 with rsp0_data=12 in cycle N+1; port 1 stays idle.
- Both ports valid from first cycle after reset, held for 4 cycles: port 0 mode 0001 with src1=0x10, imm=0xFFFFFFFF; port 1 mode 0100 with src1=3, src2=9; both rsp_ready=1 -> grants alternate 0,1,0,1; rsp0_data=0x0F; rsp1_data=4.
- Port 1 mode 1000 with src1=0xFFFFFFFE (-2), src2=1 -> rsp1_data=4. Swap the operands -> rsp1_data=2. Equal operands -> 0.
- Backpressure: rsp0_ready=0 after one port-0 result 0x20 -> req0_ready=0 and rsp0_data stays 0x20; port 1 requests are still granted every cycle. Raising rsp0_ready with req0 pending -> drain and new accept in the same cycle, and rsp0_valid stays 1.
- Reset mid-operation: rsp0_valid=1 and rsp1_valid=1, then rst_n=0 for one cycle -> both rsp_valid=0 and data=0 next cycle; the next conflict is granted to port 0.
- With EXU_ARB_PERF_EN: 3 conflict cycles and 2 solo port-1 accepts -> perf_grant0=2 (grants 0,1,0 across the conflicts), perf_grant1=3, perf_conflict=3.
